// File: rtl/gelato_issue_scheduler.sv
// Round-robin warp issue scheduler with per-warp in-flight credits,
// a single-entry registered output stage and per-warp flush.
module gelato_issue_scheduler #(
   parameter int WARP_NUM     = 32,
   parameter int INST_W       = 64,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rdy,
   input  logic [WARP_NUM-1:0]           ibuf_valid,
   input  logic [WARP_NUM*INST_W-1:0]    ibuf_inst,
   output logic [WARP_NUM-1:0]           ibuf_pop,
   input  logic [WARP_NUM-1:0]           sb_ready,
   input  logic                          wb_valid,
   input  logic [$clog2(WARP_NUM)-1:0]   wb_warp_num,
   input  logic                          flush_valid,
   input  logic [$clog2(WARP_NUM)-1:0]   flush_warp_num,
   output logic                          issue_valid,
   input  logic                          issue_ready,
   output logic [$clog2(WARP_NUM)-1:0]   issue_warp_num,
   output logic [INST_W-1:0]             issue_inst,
   output logic                          credit_err
);

   localparam int WW = $clog2(WARP_NUM);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(MAX_INFLIGHT);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WW-1:0]     warp_q, warp_d;
   logic [WW-1:0]     last_q, last_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              err_q, err_d;
   logic [CW-1:0]     credit_q [WARP_NUM];
   logic [CW-1:0]     credit_d [WARP_NUM];

   logic [WARP_NUM-1:0] eligible;
   logic [WW-1:0]       sel;
   logic                sel_found;
   logic                load;
   logic                accept;
   logic                flush_hit;

   always_comb begin
      eligible = '0;
      for (int w = 0; w < WARP_NUM; w++) begin
         eligible[w] = ibuf_valid[w] & sb_ready[w]
                     & (credit_q[w] != '0)
                     & ~(flush_valid & (flush_warp_num == WW'(w)));
      end
   end

   // Scan starts just after the last issued warp; last_q itself wraps to the end.
   always_comb begin : pick
      logic [WW-1:0] idx;
      idx       = '0;
      sel       = '0;
      sel_found = 1'b0;
      for (int i = 1; i <= WARP_NUM; i++) begin
         idx = last_q + WW'(i);
         if (!sel_found && eligible[idx]) begin
            sel_found = 1'b1;
            sel       = idx;
         end
      end
   end

   assign accept    = rdy & (state_q == HOLD) & issue_ready;
   assign load      = rst_n & rdy & sel_found
                    & ((state_q == EMPTY) | issue_ready);
   assign flush_hit = rdy & flush_valid & (state_q == HOLD)
                    & ~issue_ready & (warp_q == flush_warp_num);

   always_comb begin
      ibuf_pop = '0;
      if (load) begin
         ibuf_pop[sel] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      warp_d  = warp_q;
      inst_d  = inst_q;
      last_d  = last_q;
      if (load) begin
         state_d = HOLD;
         warp_d  = sel;
         inst_d  = ibuf_inst[INST_W*int'(sel) +: INST_W];
         last_d  = sel;
      end else if (flush_hit | accept) begin
         state_d = EMPTY;
      end
   end

   // A writeback at full credit is dropped and flagged instead of counted.
   always_comb begin : credits
      logic [CW:0] sum;
      logic        inc_wb;
      logic        inc_fl;
      logic        dec;
      sum    = '0;
      inc_wb = 1'b0;
      inc_fl = 1'b0;
      dec    = 1'b0;
      for (int w = 0; w < WARP_NUM; w++) begin
         inc_wb = rdy & wb_valid & (wb_warp_num == WW'(w))
                & (credit_q[w] != CRED_MAX);
         inc_fl = flush_hit & (warp_q == WW'(w));
         dec    = load & (sel == WW'(w));
         sum    = {1'b0, credit_q[w]}
                + (CW+1)'(inc_wb)
                + (CW+1)'(inc_fl)
                - (CW+1)'(dec);
         if (sum > {1'b0, CRED_MAX}) begin
            credit_d[w] = CRED_MAX;
         end else begin
            credit_d[w] = sum[CW-1:0];
         end
      end
      err_d = err_q
            | (rdy & wb_valid & (credit_q[wb_warp_num] == CRED_MAX));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         warp_q  <= '0;
         inst_q  <= '0;
         last_q  <= '1;
         err_q   <= 1'b0;
         for (int w = 0; w < WARP_NUM; w++) begin
            credit_q[w] <= CRED_MAX;
         end
      end else begin
         state_q <= state_d;
         warp_q  <= warp_d;
         inst_q  <= inst_d;
         last_q  <= last_d;
         err_q   <= err_d;
         for (int w = 0; w < WARP_NUM; w++) begin
            credit_q[w] <= credit_d[w];
         end
      end
   end

   assign issue_valid    = (state_q == HOLD);
   assign issue_warp_num = warp_q;
   assign issue_inst     = inst_q;
   assign credit_err     = err_q;

endmodule

// File: tb/tb_gelato_issue_scheduler.sv
// Bench for gelato_issue_scheduler: directed vector table, hand
// sequences and randomized traffic against a behavioural model.
module tb_gelato_issue_scheduler;

   localparam int N    = 32;
   localparam int IW   = 64;
   localparam int MAXI = 4;
   localparam int WW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            rdy;
   logic [N-1:0]    ibuf_valid;
   logic [N*IW-1:0] ibuf_inst;
   logic [N-1:0]    ibuf_pop;
   logic [N-1:0]    sb_ready;
   logic            wb_valid;
   logic [WW-1:0]   wb_warp_num;
   logic            flush_valid;
   logic [WW-1:0]   flush_warp_num;
   logic            issue_valid;
   logic            issue_ready;
   logic [WW-1:0]   issue_warp_num;
   logic [IW-1:0]   issue_inst;
   logic            credit_err;

   gelato_issue_scheduler #(
      .WARP_NUM     (N),
      .INST_W       (IW),
      .MAX_INFLIGHT (MAXI)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .ibuf_valid     (ibuf_valid),
      .ibuf_inst      (ibuf_inst),
      .ibuf_pop       (ibuf_pop),
      .sb_ready       (sb_ready),
      .wb_valid       (wb_valid),
      .wb_warp_num    (wb_warp_num),
      .flush_valid    (flush_valid),
      .flush_warp_num (flush_warp_num),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_warp_num (issue_warp_num),
      .issue_inst     (issue_inst),
      .credit_err     (credit_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bit            m_valid;
   int            m_warp;
   logic [IW-1:0] m_inst;
   int            m_last;
   int            m_cred [N];
   bit            m_err;
   logic [N-1:0]  last_pop;

   typedef struct {
      bit          r;
      bit          rd;
      logic [31:0] iv;
      bit          ir;
      bit          wv;
      int          ww;
      bit          fv;
      int          fw;
      logic [31:0] pop;
      bit          val;
      int          warp;
   } vec_t;

   vec_t tbl [$];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [IW-1:0] pay(input int w);
      return {32'hC0DE_0000 + 32'(w), 32'h5A5A_0000 + 32'(w)};
   endfunction

   task automatic set_payloads();
      for (int w = 0; w < N; w++) ibuf_inst[w*IW +: IW] = pay(w);
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_warp  = 0;
      m_inst  = '0;
      m_last  = N - 1;
      m_err   = 1'b0;
      for (int w = 0; w < N; w++) m_cred[w] = MAXI;
   endtask

   // One clock: check the pop before the edge, advance the model, check outputs after.
   task automatic step();
      int            sel;
      int            c;
      int            w;
      bit            ld;
      bit            fh;
      logic [N-1:0]  pe;
      int            nc [N];
      bit            nv;
      int            nw;
      int            nl;
      bit            ne;
      logic [IW-1:0] pl;
      @(negedge clk);
      sel = -1;
      if (rst_n && rdy) begin
         for (int k = 1; k <= N; k++) begin
            w = (m_last + k) % N;
            if (sel < 0 && ibuf_valid[w] && sb_ready[w] && m_cred[w] > 0
                && !(flush_valid && int'(flush_warp_num) == w))
               sel = w;
         end
      end
      ld = rst_n && rdy && (!m_valid || issue_ready) && sel >= 0;
      pe = '0;
      if (ld) pe[sel] = 1'b1;
      check("pop", 64'(ibuf_pop), 64'(pe));
      last_pop = ibuf_pop;
      nv = m_valid;
      nw = m_warp;
      pl = m_inst;
      nl = m_last;
      ne = m_err;
      nc = m_cred;
      if (!rst_n) begin
         nv = 1'b0;
         nw = 0;
         pl = '0;
         nl = N - 1;
         ne = 1'b0;
         for (int i = 0; i < N; i++) nc[i] = MAXI;
      end else if (rdy) begin
         fh = flush_valid && m_valid && !issue_ready
              && int'(flush_warp_num) == m_warp;
         for (int i = 0; i < N; i++) begin
            c = m_cred[i];
            if (wb_valid && int'(wb_warp_num) == i) begin
               if (m_cred[i] == MAXI) ne = 1'b1;
               else c++;
            end
            if (fh && i == m_warp) c++;
            if (ld && i == sel) c--;
            if (c > MAXI) c = MAXI;
            nc[i] = c;
         end
         if (ld) begin
            nv = 1'b1;
            nw = sel;
            pl = ibuf_inst[sel*IW +: IW];
            nl = sel;
         end else if (fh || (m_valid && issue_ready)) begin
            nv = 1'b0;
         end
      end
      @(posedge clk);
      m_valid = nv;
      m_warp  = nw;
      m_inst  = pl;
      m_last  = nl;
      m_err   = ne;
      m_cred  = nc;
      #1;
      check("valid", 64'(issue_valid), 64'(m_valid));
      check("warp", 64'(issue_warp_num), 64'(m_warp));
      check("inst", 64'(issue_inst), 64'(m_inst));
      check("credit_err", 64'(credit_err), 64'(m_err));
   endtask

   task automatic idle();
      rst_n          = 1'b1;
      rdy            = 1'b1;
      ibuf_valid     = '0;
      sb_ready       = '1;
      issue_ready    = 1'b1;
      wb_valid       = 1'b0;
      wb_warp_num    = '0;
      flush_valid    = 1'b0;
      flush_warp_num = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(bit r, bit rd, logic [31:0] iv, bit ir,
                               bit wv, int ww, bit fv, int fw,
                               logic [31:0] pop, bit val, int warp);
      vec_t v;
      v.r = r; v.rd = rd; v.iv = iv; v.ir = ir;
      v.wv = wv; v.ww = ww; v.fv = fv; v.fw = fw;
      v.pop = pop; v.val = val; v.warp = warp;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      rst_n          = v.r;
      rdy            = v.rd;
      ibuf_valid     = v.iv;
      sb_ready       = '1;
      issue_ready    = v.ir;
      wb_valid       = v.wv;
      wb_warp_num    = WW'(v.ww);
      flush_valid    = v.fv;
      flush_warp_num = WW'(v.fw);
      step();
      check("tbl_pop", 64'(last_pop), 64'(v.pop));
      check("tbl_valid", 64'(issue_valid), 64'(v.val));
      check("tbl_warp", 64'(issue_warp_num), 64'(v.warp));
      if (v.val) check("tbl_inst", 64'(issue_inst), pay(v.warp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [31:0] mask;
      model_reset();
      idle();
      set_payloads();
      last_pop = '0;

      // reset, round robin over warps 0..2, credit exhaustion on warp 5
      tbl.push_back(mk(0,1,32'h0,1,0,0,0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,32'h7,1,0,0,0,0, 32'h0,0,0));
      tbl.push_back(mk(1,1,32'h7,1,0,0,0,0, 32'h1,1,0));
      tbl.push_back(mk(1,1,32'h7,1,0,0,0,0, 32'h2,1,1));
      tbl.push_back(mk(1,1,32'h7,1,0,0,0,0, 32'h4,1,2));
      tbl.push_back(mk(1,1,32'h7,1,0,0,0,0, 32'h1,1,0));
      tbl.push_back(mk(1,1,32'h7,1,0,0,0,0, 32'h2,1,1));
      tbl.push_back(mk(1,1,32'h7,1,0,0,0,0, 32'h4,1,2));
      tbl.push_back(mk(0,1,32'h7,1,0,0,0,0, 32'h0,0,0));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h20,1,5));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h20,1,5));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h20,1,5));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h20,1,5));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h0,0,5));
      tbl.push_back(mk(1,1,32'h20,1,1,5,0,0, 32'h0,0,5));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h20,1,5));
      tbl.push_back(mk(1,1,32'h20,1,0,0,0,0, 32'h0,0,5));
      tbl.push_back(mk(0,1,32'h0,1,0,0,0,0, 32'h0,0,0));
      foreach (tbl[i]) apply(tbl[i]);

      // stall on warp 3 with a changing head payload
      idle();
      ibuf_valid  = 32'h18;
      issue_ready = 1'b0;
      step();
      check("hold_load_pop", 64'(last_pop), 64'h8);
      check("hold_load_warp", 64'(issue_warp_num), 64'd3);
      for (int i = 0; i < 3; i++) begin
         ibuf_inst[3*IW +: IW] = {$urandom, $urandom};
         step();
         check("hold_pop", 64'(last_pop), 64'h0);
         check("hold_warp", 64'(issue_warp_num), 64'd3);
         check("hold_inst", issue_inst, pay(3));
      end
      issue_ready = 1'b1;
      step();
      check("hold_next_pop", 64'(last_pop), 64'h10);
      check("hold_next_warp", 64'(issue_warp_num), 64'd4);
      set_payloads();

      // flush of held warp 7, stalled then accepted
      for (int acc = 0; acc < 2; acc++) begin
         do_reset();
         ibuf_valid  = 32'h80;
         issue_ready = 1'b0;
         step();
         flush_valid    = 1'b1;
         flush_warp_num = WW'(7);
         issue_ready    = 1'(acc);
         step();
         check("flush_pop", 64'(last_pop), 64'h0);
         check("flush_valid", 64'(issue_valid), 64'h0);
         flush_valid = 1'b0;
         issue_ready = 1'b1;
         cnt = 0;
         for (int i = 0; i < 6; i++) begin
            step();
            if (issue_valid) cnt++;
         end
         check(acc ? "flush_acc_credit" : "flush_credit",
               64'(cnt), acc ? 64'd3 : 64'd4);
      end

      // credit exhaustion and same-cycle issue/writeback on warp 2
      do_reset();
      ibuf_valid = 32'h4;
      for (int i = 0; i < 4; i++) step();
      step();
      check("blocked_pop", 64'(last_pop), 64'h0);
      wb_valid    = 1'b1;
      wb_warp_num = WW'(2);
      step();
      check("wb_no_pop", 64'(last_pop), 64'h0);
      step();
      check("wb_issue_pop", 64'(last_pop), 64'h4);
      wb_valid = 1'b0;
      step();
      check("same_cycle_pop", 64'(last_pop), 64'h4);
      step();
      check("drained_pop", 64'(last_pop), 64'h0);
      ibuf_valid  = '0;
      wb_valid    = 1'b1;
      wb_warp_num = WW'(9);
      step();
      check("err_set", 64'(credit_err), 64'h1);
      wb_valid = 1'b0;
      step();
      step();
      check("err_sticky", 64'(credit_err), 64'h1);

      // rdy freeze, resume from saved pointer, reset mid-hold
      ibuf_valid = 32'hF0;
      step();
      check("pre_freeze_a", 64'(issue_warp_num), 64'd4);
      step();
      check("pre_freeze_b", 64'(issue_warp_num), 64'd5);
      rdy            = 1'b0;
      wb_valid       = 1'b1;
      wb_warp_num    = WW'(4);
      flush_valid    = 1'b1;
      flush_warp_num = WW'(5);
      for (int i = 0; i < 2; i++) begin
         step();
         check("freeze_pop", 64'(last_pop), 64'h0);
         check("freeze_valid", 64'(issue_valid), 64'h1);
         check("freeze_warp", 64'(issue_warp_num), 64'd5);
      end
      rdy         = 1'b1;
      wb_valid    = 1'b0;
      flush_valid = 1'b0;
      step();
      check("resume_pop", 64'(last_pop), 64'h40);
      check("resume_warp", 64'(issue_warp_num), 64'd6);
      rst_n = 1'b0;
      step();
      check("rst_valid", 64'(issue_valid), 64'h0);
      check("rst_warp", 64'(issue_warp_num), 64'h0);
      check("rst_err", 64'(credit_err), 64'h0);
      rst_n = 1'b1;
      step();
      check("post_rst_warp", 64'(issue_warp_num), 64'd4);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         rdy   = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 2))
            0:       mask = 32'h0000_000F;
            1:       mask = 32'h0000_FF00;
            default: mask = 32'hFFFF_FFFF;
         endcase
         ibuf_valid  = $urandom & mask;
         sb_ready    = $urandom | $urandom;
         issue_ready = ($urandom_range(0, 3) != 0);
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_warp_num = WW'($urandom_range(0, 15));
         flush_valid = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1) == 0) flush_warp_num = WW'(m_warp);
         else flush_warp_num = WW'($urandom_range(0, N - 1));
         for (int w = 0; w < N; w++) ibuf_inst[w*IW +: IW] = {$urandom, $urandom};
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
